// File: rtl/prof_sb_scheduler_if.sv
// Handshake/bus bundle between the PROF subblock scheduler and its neighbours.
// The master side drives CU setup and flow control. The slave side is the scheduler.
interface prof_sb_scheduler_if #(parameter int SB_DIM_W = 6);
  logic                start, abort, prof_on, src_valid, out_ready;
  logic [SB_DIM_W-1:0] cu_w_sb, cu_h_sb;
  logic                src_ack, pdof_en, pdof_export, pdof_enab_prof, out_valid, busy, done;
  logic [SB_DIM_W-1:0] sb_x, sb_y;

  modport master (
    output start, abort, cu_w_sb, cu_h_sb, prof_on, src_valid, out_ready,
    input  src_ack, pdof_en, pdof_export, pdof_enab_prof, sb_x, sb_y, out_valid, busy, done
  );
  modport slave (
    input  start, abort, cu_w_sb, cu_h_sb, prof_on, src_valid, out_ready,
    output src_ack, pdof_en, pdof_export, pdof_enab_prof, sb_x, sb_y, out_valid, busy, done
  );
endinterface

// File: rtl/prof_sb_scheduler.sv
// Walks every 4x4 subblock of an affine CU through pdof: FETCH -> GRAD -> EXPORT -> OUT.
// Optional stall counter is enabled by defining PROF_SCHED_PERF_EN.
module prof_sb_scheduler #(
  parameter int SB_DIM_W = 6,
  parameter int PERF_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  prof_sb_scheduler_if.slave bus
`ifdef PROF_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, GRAD, EXPORT, OUT, DONE} state_t;

  state_t              state;
  logic [SB_DIM_W-1:0] w, h, x, y;
  logic                src_ack, pdof_en, pdof_export, enab, out_valid, busy, done;
  logic                x_end, last;

  assign x_end = (x == w - SB_DIM_W'(1));
  assign last  = x_end && (y == h - SB_DIM_W'(1));

  assign bus.src_ack        = src_ack;
  assign bus.pdof_en        = pdof_en;
  assign bus.pdof_export    = pdof_export;
  assign bus.pdof_enab_prof = enab;
  assign bus.sb_x           = x;
  assign bus.sb_y           = y;
  assign bus.out_valid      = out_valid;
  assign bus.busy           = busy;
  assign bus.done           = done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      w           <= SB_DIM_W'(1);
      h           <= SB_DIM_W'(1);
      x           <= '0;
      y           <= '0;
      src_ack     <= 1'b0;
      pdof_en     <= 1'b0;
      pdof_export <= 1'b0;
      enab        <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // single-cycle strobes default low; the state that owns them raises them
      src_ack     <= 1'b0;
      pdof_en     <= 1'b0;
      pdof_export <= 1'b0;
      done        <= 1'b0;
      if (bus.abort) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        busy      <= 1'b0;
        x         <= '0;
        y         <= '0;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            w     <= (bus.cu_w_sb == '0) ? SB_DIM_W'(1) : bus.cu_w_sb;
            h     <= (bus.cu_h_sb == '0) ? SB_DIM_W'(1) : bus.cu_h_sb;
            enab  <= bus.prof_on;
            x     <= '0;
            y     <= '0;
            busy  <= 1'b1;
            state <= FETCH;
          end
          FETCH: if (bus.src_valid) begin
            pdof_en <= 1'b1;
            state   <= GRAD;
          end
          GRAD: begin
            pdof_export <= 1'b1;
            src_ack     <= 1'b1;
            state       <= EXPORT;
          end
          EXPORT: begin
            out_valid <= 1'b1;
            state     <= OUT;
          end
          OUT: if (bus.out_ready) begin
            out_valid <= 1'b0;
            // counters park at 0 after the last subblock so IDLE always shows (0,0)
            if (last) begin
              x     <= '0;
              y     <= '0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              x     <= x_end ? '0 : x + SB_DIM_W'(1);
              y     <= x_end ? y + SB_DIM_W'(1) : y;
              state <= FETCH;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PROF_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (state == IDLE && bus.start && !bus.abort)
      stall_cnt <= '0;
    else if (((state == FETCH && !bus.src_valid) || (state == OUT && !bus.out_ready)) && !(&stall_cnt))
      stall_cnt <= stall_cnt + PERF_W'(1);
  end
`endif

endmodule

// File: tb/tb_prof_sb_scheduler.sv
// Directed bench for prof_sb_scheduler: a subblock-index model is compared every cycle,
// and literal per-scenario expectations pin the model.
module tb_prof_sb_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prof_sb_scheduler_if #(.SB_DIM_W(6)) bus();
`ifdef PROF_SCHED_PERF_EN
  logic [15:0] stall_cnt;
  prof_sb_scheduler #(.SB_DIM_W(6), .PERF_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .stall_cnt(stall_cnt));
`else
  prof_sb_scheduler #(.SB_DIM_W(6), .PERF_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a CU is a linear list of w*h subblocks, index k; each takes phases
  // 0 wait-src, 1 grad, 2 export, 3 wait-out.
  int m_run, m_fin, m_ph, m_k, m_w, m_h, m_prof, m_stall;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_fin = 0; m_ph = 0; m_k = 0; m_w = 1; m_h = 1; m_prof = 0; m_stall = 0;
    end else begin
      if (m_run != 0 && ((m_ph == 0 && !bus.src_valid) || (m_ph == 3 && !bus.out_ready)) && m_stall < 65535)
        m_stall++;
      if (bus.abort) begin
        m_run = 0; m_fin = 0; m_ph = 0; m_k = 0;
      end else if (m_fin != 0) begin
        m_fin = 0;
      end else if (m_run == 0) begin
        if (bus.start) begin
          m_run = 1; m_ph = 0; m_k = 0; m_stall = 0;
          m_w = (bus.cu_w_sb == 0) ? 1 : int'(bus.cu_w_sb);
          m_h = (bus.cu_h_sb == 0) ? 1 : int'(bus.cu_h_sb);
          m_prof = int'(bus.prof_on);
        end
      end else if (m_ph == 0) begin
        if (bus.src_valid) m_ph = 1;
      end else if (m_ph == 3) begin
        if (bus.out_ready) begin
          m_ph = 0;
          if (m_k == m_w * m_h - 1) begin m_run = 0; m_fin = 1; m_k = 0; end
          else m_k++;
        end
      end else begin
        m_ph++;
      end
    end
  end

  // Compare process plus event log for the scenario checks.
  int cyc = 0, n_en, n_exp, n_ack, n_done, n_ov, n_ovx, n_xbad, n_prof, n_noprof, done_cyc;
  logic [11:0] hs_q[$];
  int hs_cyc[$];
  always @(negedge clk) begin
    cyc++;
    chk("busy",      bus.busy,           (m_run != 0 || m_fin != 0));
    chk("done",      bus.done,           (m_fin != 0));
    chk("pdof_en",   bus.pdof_en,        (m_run != 0 && m_ph == 1));
    chk("export",    bus.pdof_export,    (m_run != 0 && m_ph == 2));
    chk("src_ack",   bus.src_ack,        (m_run != 0 && m_ph == 2));
    chk("out_valid", bus.out_valid,      (m_run != 0 && m_ph == 3));
    chk("enab_prof", bus.pdof_enab_prof, m_prof);
    chk("sb_x",      bus.sb_x,           m_k % m_w);
    chk("sb_y",      bus.sb_y,           m_k / m_w);
`ifdef PROF_SCHED_PERF_EN
    chk("stall_cnt", stall_cnt,          m_stall);
`endif
    if (bus.pdof_en)     n_en++;
    if (bus.pdof_export) n_exp++;
    if (bus.src_ack)     n_ack++;
    if (bus.done) begin n_done++; done_cyc = cyc; end
    if (bus.out_valid) begin
      n_ov++;
      if (bus.pdof_export) n_ovx++;
      if (!bus.out_ready && bus.sb_x != 0) n_xbad++;
      if (bus.out_ready) begin hs_q.push_back({bus.sb_x, bus.sb_y}); hs_cyc.push_back(cyc); end
    end
    if (bus.busy && bus.pdof_enab_prof)  n_prof++;
    if (bus.busy && !bus.pdof_enab_prof) n_noprof++;
  end

  task automatic clr();
    n_en = 0; n_exp = 0; n_ack = 0; n_done = 0; n_ov = 0; n_ovx = 0; n_xbad = 0;
    n_prof = 0; n_noprof = 0; done_cyc = 0;
    hs_q.delete(); hs_cyc.delete();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic go(input int w, input int h, input logic p);
    bus.cu_w_sb = 6'(w); bus.cu_h_sb = 6'(h); bus.prof_on = p;
    bus.start = 1'b1; step(1); bus.start = 1'b0;
  endtask

  task automatic run_to_done(input string name);
    int d0 = n_done;
    int ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (n_done > d0) begin ok = 1; break; end
    end
    if (ok == 0) chk({name, "_timeout"}, 0, 1);
    step(1);
  endtask

  initial begin
    bus.start = 0; bus.abort = 0; bus.cu_w_sb = 0; bus.cu_h_sb = 0; bus.prof_on = 0;
    bus.src_valid = 0; bus.out_ready = 0;
    clr();
    step(2); #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_ov", bus.out_valid, 0);
    rst_n = 1'b1; step(1);

    // 1: 2x1, prof on, free-running flow control
    clr(); bus.src_valid = 1; bus.out_ready = 1;
    go(2, 1, 1'b1); run_to_done("t1");
    chk("t1_hs", hs_q.size(), 2);
    if (hs_cyc.size() == 2) begin
      chk("t1_gap", hs_cyc[1] - hs_cyc[0], 4);
      chk("t1_done_lat", done_cyc - hs_cyc[1], 1);
    end
    chk("t1_done", n_done, 1);
    chk("t1_noprof", n_noprof, 0);

    // 2: 2x2 raster order
    clr(); go(2, 2, 1'b1); run_to_done("t2");
    chk("t2_hs", hs_q.size(), 4);
    if (hs_q.size() == 4) begin
      chk("t2_p0", hs_q[0], {6'd0, 6'd0});
      chk("t2_p1", hs_q[1], {6'd1, 6'd0});
      chk("t2_p2", hs_q[2], {6'd0, 6'd1});
      chk("t2_p3", hs_q[3], {6'd1, 6'd1});
    end
    chk("t2_done", n_done, 1);
    chk("t2_busy_after", bus.busy, 0);

    // 3: src_valid low 5 FETCH cycles, 1x1 CU
    clr(); bus.src_valid = 0;
    go(1, 1, 1'b1); step(5);
    chk("t3_no_en", n_en, 0);
    bus.src_valid = 1; run_to_done("t3");
    chk("t3_en", n_en, 1);
    chk("t3_exp", n_exp, 1);
    chk("t3_ack", n_ack, 1);
`ifdef PROF_SCHED_PERF_EN
    chk("t3_stall", stall_cnt, 5);
`endif

    // 4: out_ready low 3 cycles in OUT of subblock (0,0) of a 2x1 CU
    clr(); bus.out_ready = 0;
    go(2, 1, 1'b1); step(3); step(3);
    bus.out_ready = 1; run_to_done("t4");
    chk("t4_ov_cycles", n_ov, 5);
    chk("t4_exp_in_out", n_ovx, 0);
    chk("t4_x_stable", n_xbad, 0);
    chk("t4_exp", n_exp, 2);

    // 5: abort in EXPORT of (1,0) of a 4x1 CU, then abort+start, then 1x1 bypass
    clr(); go(4, 1, 1'b1); step(6);
    chk("t5_in_export", bus.pdof_export, 1);
    bus.abort = 1; step(1); bus.abort = 0;
    chk("t5_idle", bus.busy, 0);
    step(3);
    chk("t5_no_done", n_done, 0);
    bus.abort = 1; bus.start = 1; step(1); bus.abort = 0; bus.start = 0;
    step(1);
    chk("t5_abort_wins", bus.busy, 0);
    clr(); go(1, 1, 1'b0); run_to_done("t5b");
    chk("t5_hs", hs_q.size(), 1);
    chk("t5_prof_cycles", n_prof, 0);
    chk("t5_enab", bus.pdof_enab_prof, 0);

    // 6: async reset while in OUT, then a full 2x2 CU
    clr(); bus.out_ready = 0;
    go(2, 1, 1'b1); step(3);
    chk("t6_in_out", bus.out_valid, 1);
    #1 rst_n = 1'b0; #1;
    chk("t6_rst_ov", bus.out_valid, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_enab", bus.pdof_enab_prof, 0);
    chk("t6_rst_ack", bus.src_ack, 0);
    step(2); rst_n = 1'b1; step(1);
    clr(); bus.out_ready = 1;
    go(2, 2, 1'b1); run_to_done("t6");
    chk("t6_hs", hs_q.size(), 4);
    chk("t6_done", n_done, 1);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
